// File: rtl/iram_icb_arb_pkg.sv
// Shared ICB fabric constants and arbiter state encoding.
package iram_icb_arb_pkg;

  localparam int unsigned ICB_AW = 32;
  localparam int unsigned ICB_DW = 32;
  localparam int unsigned ICB_MW = 4;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_RD_WAIT = 2'd1;
  localparam logic [1:0] ARB_WR_RSP  = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin grant: a tie goes to the requester that did not win last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/iram_icb_arb.sv
// Two-master ICB arbiter for the iram slave; one outstanding transaction,
// read responses forwarded from the slave, write responses generated locally.
module iram_icb_arb
  import iram_icb_arb_pkg::*;
#(
  parameter int unsigned AW    = ICB_AW,
  parameter int unsigned DW    = ICB_DW,
  parameter int unsigned DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_icb_cmd_valid,
  output logic              m0_icb_cmd_ready,
  input  logic [AW-1:0]     m0_icb_cmd_addr,
  input  logic              m0_icb_cmd_read,
  input  logic [DW-1:0]     m0_icb_cmd_wdata,
  input  logic [ICB_MW-1:0] m0_icb_cmd_wmask,
  output logic              m0_icb_rsp_valid,
  input  logic              m0_icb_rsp_ready,
  output logic              m0_icb_rsp_err,
  output logic [DW-1:0]     m0_icb_rsp_rdata,

  input  logic              m1_icb_cmd_valid,
  output logic              m1_icb_cmd_ready,
  input  logic [AW-1:0]     m1_icb_cmd_addr,
  input  logic              m1_icb_cmd_read,
  input  logic [DW-1:0]     m1_icb_cmd_wdata,
  input  logic [ICB_MW-1:0] m1_icb_cmd_wmask,
  output logic              m1_icb_rsp_valid,
  input  logic              m1_icb_rsp_ready,
  output logic              m1_icb_rsp_err,
  output logic [DW-1:0]     m1_icb_rsp_rdata,

  output logic              s_icb_cmd_valid,
  input  logic              s_icb_cmd_ready,
  output logic [AW-1:0]     s_icb_cmd_addr,
  output logic              s_icb_cmd_read,
  output logic [DW-1:0]     s_icb_cmd_wdata,
  output logic [ICB_MW-1:0] s_icb_cmd_wmask,
  input  logic              s_icb_rsp_valid,
  output logic              s_icb_rsp_ready,
  input  logic              s_icb_rsp_err,
  input  logic [DW-1:0]     s_icb_rsp_rdata
);

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  logic [1:0]    state, state_nxt;
  logic          owner, owner_nxt;
  logic          rr_last, rr_last_nxt;
  logic          wr_err, wr_err_nxt;
  logic          grant, any_req;
  logic          cmd_hs, owner_rsp_ready;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;

  rr_arb2 u_rr_arb2 (
    .req   ({m1_icb_cmd_valid, m0_icb_cmd_valid}),
    .last  (rr_last),
    .grant (grant),
    .any   (any_req)
  );

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      owner   <= 1'b0;
      rr_last <= 1'b1;
      wr_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rr_last <= rr_last_nxt;
      wr_err  <= wr_err_nxt;
    end
  end

  // Next-state, command mux and response routing.
  always_comb begin
    state_nxt        = state;
    owner_nxt        = owner;
    rr_last_nxt      = rr_last;
    wr_err_nxt       = wr_err;
    s_icb_cmd_valid  = 1'b0;
    s_icb_rsp_ready  = 1'b1;
    rsp_valid        = 1'b0;
    rsp_err          = 1'b0;
    rsp_rdata        = '0;
    m0_icb_cmd_ready = 1'b0;
    m1_icb_cmd_ready = 1'b0;
    cmd_hs           = 1'b0;
    owner_rsp_ready  = owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;

    s_icb_cmd_addr   = grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    s_icb_cmd_read   = grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
    s_icb_cmd_wdata  = grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    s_icb_cmd_wmask  = grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    case (state)
      ARB_IDLE: begin
        // Held off during reset so a master never sees a handshake it was not given.
        s_icb_cmd_valid  = rst_n & any_req;
        m0_icb_cmd_ready = s_icb_cmd_valid & ~grant & s_icb_cmd_ready;
        m1_icb_cmd_ready = s_icb_cmd_valid &  grant & s_icb_cmd_ready;
        cmd_hs           = s_icb_cmd_valid & s_icb_cmd_ready;
        if (cmd_hs) begin
          owner_nxt   = grant;
          rr_last_nxt = grant;
          if (s_icb_cmd_read) begin
            state_nxt = ARB_RD_WAIT;
          end else begin
            state_nxt  = ARB_WR_RSP;
            wr_err_nxt = {2'b00, s_icb_cmd_addr[AW-1:2]} >= DEPTH_W;
          end
        end
      end
      ARB_RD_WAIT: begin
        rsp_valid       = s_icb_rsp_valid;
        rsp_err         = s_icb_rsp_err;
        rsp_rdata       = s_icb_rsp_rdata;
        s_icb_rsp_ready = owner_rsp_ready;
        if (s_icb_rsp_valid && owner_rsp_ready) state_nxt = ARB_IDLE;
      end
      ARB_WR_RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = wr_err;
        if (owner_rsp_ready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign m0_icb_rsp_valid = rsp_valid & ~owner;
  assign m0_icb_rsp_err   = rsp_err   & ~owner;
  assign m0_icb_rsp_rdata = owner ? '0 : rsp_rdata;
  assign m1_icb_rsp_valid = rsp_valid & owner;
  assign m1_icb_rsp_err   = rsp_err   & owner;
  assign m1_icb_rsp_rdata = owner ? rsp_rdata : '0;

endmodule

// File: tb/tb_iram_icb_arb.sv
// Bench for iram_icb_arb: grant table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_iram_icb_arb;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    cv, cr, crd, rv, rr, re;
  logic [AW-1:0] ca [2];
  logic [DW-1:0] cw [2];
  logic [3:0]    cm [2];
  logic [DW-1:0] rd [2];
  logic          scv, scr, sread, srv, srr, sre;
  logic [AW-1:0] sa;
  logic [DW-1:0] sw, srd;
  logic [3:0]    sm;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which transaction is pending and who won last.
  int pend_kind;   // 0 none, 1 read awaiting slave, 2 write awaiting master
  int pend_m;
  bit pend_err;
  int last_m;

  iram_icb_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(cv[0]), .m0_icb_cmd_ready(cr[0]), .m0_icb_cmd_addr(ca[0]),
    .m0_icb_cmd_read(crd[0]), .m0_icb_cmd_wdata(cw[0]), .m0_icb_cmd_wmask(cm[0]),
    .m0_icb_rsp_valid(rv[0]), .m0_icb_rsp_ready(rr[0]), .m0_icb_rsp_err(re[0]),
    .m0_icb_rsp_rdata(rd[0]),
    .m1_icb_cmd_valid(cv[1]), .m1_icb_cmd_ready(cr[1]), .m1_icb_cmd_addr(ca[1]),
    .m1_icb_cmd_read(crd[1]), .m1_icb_cmd_wdata(cw[1]), .m1_icb_cmd_wmask(cm[1]),
    .m1_icb_rsp_valid(rv[1]), .m1_icb_rsp_ready(rr[1]), .m1_icb_rsp_err(re[1]),
    .m1_icb_rsp_rdata(rd[1]),
    .s_icb_cmd_valid(scv), .s_icb_cmd_ready(scr), .s_icb_cmd_addr(sa),
    .s_icb_cmd_read(sread), .s_icb_cmd_wdata(sw), .s_icb_cmd_wmask(sm),
    .s_icb_rsp_valid(srv), .s_icb_rsp_ready(srr), .s_icb_rsp_err(sre),
    .s_icb_rsp_rdata(srd)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_kind = 0;
    pend_m    = 0;
    pend_err  = 1'b0;
    last_m    = 1;
  endtask

  function automatic int pick();
    if (cv == 2'b11) return 1 - last_m;
    return cv[1] ? 1 : 0;
  endfunction

  task automatic check_model();
    int w;
    logic [1:0] e_cr, e_rv;
    if (!rst_n) begin
      model_reset();
      chk("rst_rsp_valid", rv, 2'b00);
      chk("rst_cmd_ready", cr, 2'b00);
      return;
    end
    e_cr = 2'b00;
    e_rv = 2'b00;
    if (pend_kind == 0) begin
      chk("m_s_cmd_valid", scv, |cv);
      if (|cv) begin
        w = pick();
        e_cr[w] = scr;
        chk("m_s_addr", sa, ca[w]);
        chk("m_s_read", sread, crd[w]);
        chk("m_s_wdata", sw, cw[w]);
        chk("m_s_wmask", sm, cm[w]);
      end
      chk("m_cmd_ready", cr, e_cr);
      chk("m_rsp_valid", rv, e_rv);
      chk("m_s_rsp_ready", srr, 1'b1);
    end else begin
      chk("m_busy_s_cmd_valid", scv, 1'b0);
      chk("m_busy_cmd_ready", cr, e_cr);
      e_rv[pend_m] = (pend_kind == 1) ? srv : 1'b1;
      chk("m_busy_rsp_valid", rv, e_rv);
      if (e_rv[pend_m]) begin
        chk("m_rsp_err", re[pend_m], (pend_kind == 1) ? sre : pend_err);
        chk("m_rsp_rdata", rd[pend_m], (pend_kind == 1) ? srd : '0);
      end
      chk("m_busy_s_rsp_ready", srr, (pend_kind == 1) ? rr[pend_m] : 1'b1);
    end
  endtask

  task automatic model_clock();
    int w;
    if (!rst_n) begin
      model_reset();
    end else if (pend_kind == 0) begin
      if (|cv && scr) begin
        w         = pick();
        last_m    = w;
        pend_m    = w;
        pend_kind = crd[w] ? 1 : 2;
        pend_err  = (ca[w] / 4) >= DEPTH;
      end
    end else if (pend_kind == 1) begin
      if (srv && rr[pend_m]) pend_kind = 0;
    end else if (rr[pend_m]) begin
      pend_kind = 0;
    end
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cv = 2'b00; crd = 2'b00; rr = 2'b11;
    scr = 1'b1; srv = 1'b0; sre = 1'b0; srd = '0;
    for (int i = 0; i < 2; i++) begin
      ca[i] = '0; cw[i] = '0; cm[i] = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_rsp_valid", rv, 2'b00);
    chk("reset_cmd_ready", cr, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]    v;
    logic [1:0]    rdf;
    logic          sr;
    logic          sv;
    logic          e_scv;
    logic [1:0]    e_cr;
    logic [AW-1:0] e_addr;
    logic          e_read;
  } vec_t;

  vec_t vt [8];
  int   order [$];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    // Single-cycle IDLE grant table, each vector from a fresh reset (tie -> m0).
    vt[0] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0,   1'b0};
    vt[1] = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 32'h100, 1'b1};
    vt[2] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 32'h200, 1'b0};
    vt[3] = '{2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 2'b01, 32'h100, 1'b0};
    vt[4] = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 32'h100, 1'b1};
    vt[5] = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 32'h200, 1'b1};
    vt[6] = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0};
    vt[7] = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 32'h100, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      ca[0] = 32'h100; ca[1] = 32'h200;
      cv = vt[i].v; crd = vt[i].rdf; scr = vt[i].sr; srv = vt[i].sv;
      #1;
      chk($sformatf("tbl%0d_s_cmd_valid", i), scv, vt[i].e_scv);
      chk($sformatf("tbl%0d_cmd_ready", i), cr, vt[i].e_cr);
      chk($sformatf("tbl%0d_rsp_valid", i), rv, 2'b00);
      chk($sformatf("tbl%0d_s_rsp_ready", i), srr, 1'b1);
      if (vt[i].e_scv) begin
        chk($sformatf("tbl%0d_s_addr", i), sa, vt[i].e_addr);
        chk($sformatf("tbl%0d_s_read", i), sread, vt[i].e_read);
      end
    end

    // m0 read of 0x10, then m1 write of 0xA5A5A5A5 to 0x20 at T+2.
    do_reset();
    @(negedge clk);
    cv = 2'b01; crd = 2'b01; ca[0] = 32'h10;
    settle();
    chk("rd_m0_cmd_ready", cr, 2'b01);
    tick();
    cv = 2'b00; srv = 1'b1; srd = 32'hDEADBEEF;
    settle();
    chk("rd_m0_rsp_valid", rv, 2'b01);
    chk("rd_m0_rdata", rd[0], 32'hDEADBEEF);
    tick();
    srv = 1'b0;
    cv = 2'b10; crd = 2'b00; ca[1] = 32'h20; cw[1] = 32'hA5A5A5A5; cm[1] = 4'b0011;
    settle();
    chk("wr_s_addr", sa, 32'h20);
    chk("wr_s_wdata", sw, 32'hA5A5A5A5);
    chk("wr_s_wmask", sm, 4'b0011);
    chk("wr_m1_cmd_ready", cr, 2'b10);
    tick();
    cv = 2'b00;
    settle();
    chk("wr_m1_rsp_valid", rv, 2'b10);
    chk("wr_m1_err", re[1], 1'b0);
    chk("wr_m1_rdata", rd[1], 32'h0);
    tick();

    // Both masters hold reads for 8 transactions; grants must alternate from m0.
    do_reset();
    @(negedge clk);
    cv = 2'b11; crd = 2'b11; ca[0] = 32'h40; ca[1] = 32'h80; srv = 1'b1;
    for (int c = 0; c < 16; c++) begin
      srd = $urandom;
      settle();
      if (cr[0]) order.push_back(0);
      else if (cr[1]) order.push_back(1);
      tick();
    end
    chk("rr_grant_count", order.size(), 8);
    for (int i = 0; i < order.size(); i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);
    idle_inputs();
    settle();
    tick();

    // Write range boundary.
    cv = 2'b01; crd = 2'b00; ca[0] = 4 * DEPTH;
    settle();
    tick();
    cv = 2'b00;
    settle();
    chk("oob_err", re[0], 1'b1);
    tick();
    cv = 2'b01; ca[0] = 4 * (DEPTH - 1);
    settle();
    tick();
    cv = 2'b00;
    settle();
    chk("inrange_err", re[0], 1'b0);
    chk("inrange_rsp_valid", rv, 2'b01);
    tick();

    // Owner back-pressure in RD_WAIT with m1 waiting.
    cv = 2'b01; crd = 2'b01; ca[0] = 32'h30;
    settle();
    tick();
    cv = 2'b10; crd = 2'b10; srv = 1'b1; srd = 32'h12345678; rr = 2'b10;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp_s_rsp_ready", srr, 1'b0);
      chk("bp_rdata", rd[0], 32'h12345678);
      chk("bp_m1_cmd_ready", cr[1], 1'b0);
      tick();
    end
    rr = 2'b11;
    settle();
    chk("bp_release_s_rsp_ready", srr, 1'b1);
    tick();
    srv = 1'b0;
    settle();
    chk("bp_m1_resumes", cr, 2'b10);
    tick();

    // Reset in RD_WAIT (owner m1), stray slave response afterwards, then a tie.
    cv = 2'b11; crd = 2'b11;
    settle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_rsp_valid", rv, 2'b00);
    chk("midrst_cmd_ready", cr, 2'b00);
    tick();
    rst_n = 1'b1;
    cv = 2'b00; srv = 1'b1; srd = 32'hBAD0BAD0; rr = 2'b11;
    settle();
    chk("stray_rsp_valid", rv, 2'b00);
    chk("stray_s_rsp_ready", srr, 1'b1);
    tick();
    srv = 1'b0; cv = 2'b11; crd = 2'b11;
    settle();
    chk("post_rst_tie_m0", cr, 2'b01);
    tick();
    cv = 2'b00;
    idle_inputs();
    settle();
    tick();

    // Randomized traffic, with occasional asynchronous resets, against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      cv    = 2'($urandom);
      crd   = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 3))
          0: ca[i] = 4 * DEPTH - 4;
          1: ca[i] = 4 * DEPTH;
          2: ca[i] = 32'($urandom_range(0, 255));
          default: ca[i] = $urandom;
        endcase
        cw[i] = $urandom;
        cm[i] = 4'($urandom);
      end
      scr = ($urandom_range(0, 3) != 0);
      srv = $urandom_range(0, 1);
      sre = $urandom_range(0, 1);
      srd = $urandom;
      rr  = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      settle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/iram_icb_arb.md
# iram_icb_arb

Two-master ICB arbiter in front of the `iram` ICB slave port. It lets the core data path (m0) and the ISP/debug loader (m1) share the single slave.
- Round-robin grant, one outstanding transaction at a time.
- Reads get their response from the slave.
- The `iram` slave returns no response for writes, so the arbiter generates write responses locally.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `DEPTH`, 4096, slave word depth. A write with `addr[AW-1:2] >= DEPTH` gets `rsp_err=1`.

Ports (each `m{0,1}` bullet is instantiated once per master):
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `m{0,1}_icb_cmd_valid` in 1: master command valid.
- `m{0,1}_icb_cmd_ready` out 1: command accepted.
- `m{0,1}_icb_cmd_addr/read/wdata/wmask` in AW/1/DW/4: command payload.
- `m{0,1}_icb_rsp_valid` out 1: response valid to master.
- `m{0,1}_icb_rsp_ready` in 1: master accepts response.
- `m{0,1}_icb_rsp_err/rdata` out 1/DW: response payload.
- `s_icb_cmd_valid` out 1: command to `iram`.
- `s_icb_cmd_ready` in 1: slave accepts command.
- `s_icb_cmd_addr/read/wdata/wmask` out AW/1/DW/4: payload muxed from the granted master.
- `s_icb_rsp_valid` in 1: slave read response valid.
- `s_icb_rsp_ready` out 1: arbiter accepts slave response.
- `s_icb_rsp_err/rdata` in 1/DW: slave response payload.

## Operation
States: IDLE, RD_WAIT, WR_RSP. Registers: `state`, `owner` (1 bit), `rr_last` (1 bit), `wr_err` (1 bit).

- **IDLE, grant:**
  - Only one master valid: that master is granted.
  - Both valid: grant `~rr_last`.
  - Grant is combinational. The granted payload drives `s_icb_cmd_*`. `s_icb_cmd_valid` = OR of master valids.
  - Granted master's `cmd_ready` = `s_icb_cmd_ready`. The loser's `cmd_ready` = 0.
- **IDLE, on cmd handshake (`s_icb_cmd_valid & s_icb_cmd_ready`):**
  - `owner` <= grant; `rr_last` <= grant.
  - Read: go to RD_WAIT.
  - Write: go to WR_RSP; `wr_err` <= `addr[AW-1:2] >= DEPTH`.
- **RD_WAIT:**
  - `s_icb_cmd_valid` = 0; both master `cmd_ready` = 0.
  - `m[owner]_rsp_valid/err/rdata` = `s_icb_rsp_*`.
  - `s_icb_rsp_ready` = `m[owner]_rsp_ready`.
  - On slave rsp handshake: go to IDLE.
- **WR_RSP:**
  - `m[owner]_rsp_valid` = 1, `rsp_err` = `wr_err`, `rdata` = 0.
  - `s_icb_cmd_valid` = 0.
  - On `m[owner]_rsp_ready`: go to IDLE.
- **Non-owner and IDLE rules:**
  - Non-owner `rsp_valid` = 0 in all states.
  - In IDLE and WR_RSP, `s_icb_rsp_ready` = 1. A stray `s_icb_rsp_valid` in these states is dropped and never routed to a master.
- **Fairness:** `rr_last` updates only on cmd handshake. A master with `valid` held waits at most one transaction.
- **Reset values (async reset, including mid-transaction):**
  - IDLE, `owner`=0, `rr_last`=1 (m0 wins the first tie), `wr_err`=0.
  - All `rsp_valid` = 0 and all `cmd_ready` = 0 until the first IDLE evaluation after reset.
  - An in-flight transaction is dropped and no response is issued.

## Timing
- Cmd path (master to slave) is combinational, zero added latency.
- Read:
  - Cmd accepted at cycle T; `iram` rsp at T+1 is forwarded in the same cycle.
  - With `rsp_ready`=1, IDLE at T+2. Peak rate is 1 read per 2 cycles.
- Write:
  - Cmd accepted at T; `rsp_valid` at T+1.
  - With `rsp_ready`=1, IDLE at T+2.
- Back-pressure: if the owner holds `rsp_ready`=0, the state holds and the response stays stable. The other master stays blocked.
- Simultaneous events:
  - Response handshake and a new cmd valid in the same cycle: the new cmd is not accepted until the following IDLE cycle.
  - Both masters requesting in successive IDLE cycles: grants alternate m0, m1, m0, ...

## Structure
- Shared package holds:
  - State encoding: `ARB_IDLE`=2'd0, `ARB_RD_WAIT`=2'd1, `ARB_WR_RSP`=2'd2.
  - `ICB_AW`/`ICB_DW` constants, reused by future ICB fabric blocks.
- Sub-module `rr_arb2`: 2-request round-robin grant from `{req, last}`, purely combinational, about 15 lines. All FSM logic stays in `iram_icb_arb`.

## Test plan
- m0 reads addr 0x10 (slave returns 0xDEADBEEF at T+1) -> m0 `rsp_valid` at T+1 with rdata 0xDEADBEEF; m1 `rsp_valid` stays 0; IDLE at T+2.
- m1 writes 0xA5A5A5A5, wmask 4'b0011, to 0x20 -> `s_icb_cmd_*` equals the m1 payload at T; m1 `rsp_valid` at T+1 with err=0, rdata=0.
- Both masters hold valid reads continuously for 8 transactions -> grant order after reset is m0, m1, m0, m1, ...; 4 transactions each.
- Write to word address DEPTH (byte 4*DEPTH) -> `rsp_err`=1; in-range write at 4*(DEPTH-1) -> `rsp_err`=0.
- Owner holds `rsp_ready`=0 for 5 cycles in RD_WAIT -> `s_icb_rsp_ready`=0 and rdata stable; other master's `cmd_ready`=0 throughout; resumes on release.
- Assert `rst_n`=0 in RD_WAIT, then inject `s_icb_rsp_valid` after release -> all `rsp_valid`=0, state IDLE, stray response dropped; next tie is granted to m0.
